// File: rtl/burst_rr_sched_pkg.sv
// Shared types and width helpers for the burst round-robin scheduler.
// ARB_TIMEOUT_EN in the top enables the stall-abort counter.
package burst_rr_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Bits needed to index n items.
  function automatic int IdxW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to count from 0 up to n.
  function automatic int CntW(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/burst_rr_scheduler_rr_pick.sv
// Rotating-priority picker: first request strictly after last,
// wrapping around; one-hot, binary index and any-request out.
module rr_pick
  import burst_rr_sched_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic [N-1:0] pick_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  function automatic logic [W-1:0] rotIdx(
    input logic [W-1:0] base,
    input int           k
  );
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return W'(s);
  endfunction

  // Walk lowest priority first so the nearest request wins.
  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (req_i[rotIdx(last_i, k)]) begin
        any_o  = 1'b1;
        idx_o  = rotIdx(last_i, k);
        pick_o = '0;
        pick_o[rotIdx(last_i, k)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/burst_rr_scheduler.sv
// Round-robin burst scheduler sharing one valid/ready port.
// Define ARB_TIMEOUT_EN to abort bursts stalled TimeoutCycles.
module burst_rr_scheduler
  import burst_rr_sched_pkg::*;
#(
  parameter int NumRequests   = 8,
  parameter int MaxBurst      = 16,
  parameter int TimeoutCycles = 64
) (
  input  logic                         clk,
  input  logic                         rstN,
  input  logic [NumRequests-1:0]       reqValid,
  input  logic [NumRequests-1:0]       reqLast,
  output logic [NumRequests-1:0]       reqReady,
  output logic                         resValid,
  output logic                         resLast,
  input  logic                         resReady,
  output logic [NumRequests-1:0]       grant,
  output logic [IdxW(NumRequests)-1:0] grantIdx,
  output logic                         busy,
  output logic                         timeout
);

  localparam int IW = IdxW(NumRequests);
  localparam int BW = CntW(MaxBurst);
  localparam logic [BW-1:0] BeatMax  = BW'(MaxBurst - 1);
  localparam logic [IW-1:0] LastInit = IW'(NumRequests - 1);

  if (NumRequests < 2 || MaxBurst < 1 || TimeoutCycles < 1) begin : g_param_check
    $error("burst_rr_scheduler: illegal parameter value");
  end

  state_e                 state_q, state_d;
  logic [NumRequests-1:0] grant_q, grant_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [IW-1:0]          last_q, last_d;
  logic [BW-1:0]          beat_q, beat_d;

  logic [NumRequests-1:0] pick;
  logic [IW-1:0]          pickIdx;
  logic                   anyReq;
  logic                   beat;
  logic                   atMax;
  logic                   burstEnd;
  logic                   abort;

  rr_pick #(
    .N(NumRequests),
    .W(IW)
  ) u_pick (
    .req_i (reqValid),
    .last_i(last_q),
    .pick_o(pick),
    .idx_o (pickIdx),
    .any_o (anyReq)
  );

  assign beat     = (state_q == BURST) & reqValid[idx_q] & resReady;
  assign atMax    = (beat_q == BeatMax);
  assign burstEnd = beat & (reqLast[idx_q] | atMax);

`ifdef ARB_TIMEOUT_EN
  localparam int SW = CntW(TimeoutCycles);
  localparam logic [SW-1:0] StallMax = SW'(TimeoutCycles - 1);

  logic [SW-1:0] stall_q, stall_d;

  assign abort = (state_q == BURST) & ~beat & (stall_q == StallMax);

  always_comb begin
    stall_d = '0;
    if (state_q == BURST && !abort && !beat) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) stall_q <= '0;
    else       stall_q <= stall_d;
  end
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      last_q  <= LastInit;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    last_d  = last_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        if (anyReq) begin
          state_d = BURST;
          grant_d = pick;
          idx_d   = pickIdx;
        end
      end
      BURST: begin
        if (burstEnd || abort) begin
          state_d = IDLE;
          grant_d = '0;
          idx_d   = '0;
          last_d  = idx_q;
          beat_d  = '0;
        end else if (beat) begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    reqReady = '0;
    resValid = 1'b0;
    resLast  = 1'b0;
    if (state_q == BURST) begin
      reqReady[idx_q] = resReady;
      resValid        = reqValid[idx_q];
      resLast         = reqLast[idx_q] | atMax;
    end
  end

  assign grant    = grant_q;
  assign grantIdx = idx_q;
  assign busy     = (state_q == BURST);
  assign timeout  = abort;

endmodule

// File: tb/tb_burst_rr_scheduler.sv
// Self-checking bench for burst_rr_scheduler: directed scenarios
// plus random traffic against a transaction-level reference model.
module tb_burst_rr_scheduler;

  localparam int NR = 8;
  localparam int MB = 16;
  localparam int TO = 64;
  localparam int IW = $clog2(NR);

  logic          clk = 1'b0;
  logic          rstN;
  logic [NR-1:0] reqValid, reqLast, reqReady, grant;
  logic          resValid, resLast, resReady, busy, timeout;
  logic [IW-1:0] grantIdx;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit            rnd;
  logic [NR-1:0] en, hs, prevGrant;
  int            blen[NR];
  int            cnt[NR];
  int            lastHsCyc[NR];
  int            order[$];
  int            beats[$];
  int            grantCyc[$];
  int            toCyc;
  int            fairExp[6] = '{0, 3, 5, 0, 3, 5};

  // Reference model: owner (-1 = none), beats this turn,
  // previous winner, and cycles since the owner's last beat.
  int mOwner, mBeats, mLast, mStall;

  always #5 clk = ~clk;

  burst_rr_scheduler #(
    .NumRequests  (NR),
    .MaxBurst     (MB),
    .TimeoutCycles(TO)
  ) dut (
    .clk     (clk),
    .rstN    (rstN),
    .reqValid(reqValid),
    .reqLast (reqLast),
    .reqReady(reqReady),
    .resValid(resValid),
    .resLast (resLast),
    .resReady(resReady),
    .grant   (grant),
    .grantIdx(grantIdx),
    .busy    (busy),
    .timeout (timeout)
  );

  function automatic bit bitOf(input logic [NR-1:0] v, input int i);
    logic [NR-1:0] t;
    if (i < 0) return 1'b0;
    t = v >> i;
    return t[0];
  endfunction

  function automatic bit mBeat();
    return mOwner >= 0 && bitOf(reqValid, mOwner) && resReady;
  endfunction

  function automatic bit mTimeout();
`ifdef ARB_TIMEOUT_EN
    return mOwner >= 0 && !mBeat() && mStall == TO - 1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic mReset();
    mOwner = -1;
    mBeats = 0;
    mLast  = NR - 1;
    mStall = 0;
  endtask

  task automatic mEnd();
    mLast  = mOwner;
    mOwner = -1;
    mBeats = 0;
    mStall = 0;
  endtask

  task automatic modelStep();
    bit b, t;
    b = mBeat();
    t = mTimeout();
    if (!rstN) begin
      mReset();
    end else if (mOwner < 0) begin
      for (int k = 1; k <= NR; k++) begin
        int j;
        j = (mLast + k) % NR;
        if (mOwner < 0 && bitOf(reqValid, j)) mOwner = j;
      end
    end else if (b) begin
      mStall = 0;
      mBeats++;
      if (bitOf(reqLast, mOwner) || mBeats == MB) mEnd();
    end else if (t) begin
      mEnd();
    end else begin
      mStall++;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic checkOutputs();
    logic          eb, erv, erl;
    logic [NR-1:0] eg, er;
    eb  = (mOwner >= 0);
    eg  = eb ? (NR'(1) << mOwner) : '0;
    er  = (eb && resReady) ? eg : '0;
    erv = eb && bitOf(reqValid, mOwner);
    erl = eb && (bitOf(reqLast, mOwner) || mBeats == MB - 1);
    chk("outs",
        {44'd0, busy, grant, resValid, resLast, reqReady, timeout},
        {44'd0, eb, eg, erv, erl, er, mTimeout()});
    if (eb) chk("idx", 64'(grantIdx), 64'(mOwner));
  endtask

  task automatic cycle();
    if (rnd) begin
      reqValid = NR'($urandom | $urandom);
      reqLast  = NR'($urandom & $urandom);
      resReady = ($urandom_range(3) != 0);
    end else begin
      for (int m = 0; m < NR; m++) begin
        reqValid[m] = en[m];
        reqLast[m]  = (cnt[m] == blen[m] - 1);
      end
    end
    @(negedge clk);
    cyc++;
    checkOutputs();
    hs = reqValid & reqReady;
    if (grant != '0 && prevGrant == '0) begin
      order.push_back(int'(grantIdx));
      beats.push_back(0);
      grantCyc.push_back(cyc);
    end
    if (resValid && resReady && beats.size() > 0) beats[$] = beats[$] + 1;
    if (timeout) toCyc = cyc;
    prevGrant = grant;
    @(posedge clk);
    modelStep();
    for (int m = 0; m < NR; m++) begin
      if (hs[m]) begin
        cnt[m] = (cnt[m] + 1) % blen[m];
        lastHsCyc[m] = cyc;
      end
    end
    #1;
  endtask

  task automatic doReset(input logic [NR-1:0] e);
    rstN     = 1'b0;
    mReset();
    en       = e;
    rnd      = 1'b0;
    resReady = 1'b1;
    for (int m = 0; m < NR; m++) begin
      blen[m] = 2;
      cnt[m]  = 0;
    end
    order.delete();
    beats.delete();
    grantCyc.delete();
    prevGrant = '0;
    cycle();
    cycle();
    chk("rst_outs",
        {44'd0, busy, grant, resValid, resLast, reqReady, timeout}, 64'd0);
    chk("rst_idx", 64'(grantIdx), 64'd0);
    rstN = 1'b1;
  endtask

  initial begin
    rstN     = 1'b0;
    reqValid = '0;
    reqLast  = '0;
    resReady = 1'b1;
    toCyc    = -1;
    mReset();

    // Reset with every master requesting, then master 0 first.
    doReset('1);
    cycle();
    chk("rst_grant", 64'(grant), 64'h01);

    // Fairness across masters 0, 3, 5 with 2-beat bursts.
    doReset('0);
    en = 8'b0010_1001;
    for (int i = 0; i < 24; i++) cycle();
    for (int i = 0; i < 6; i++) begin
      chk("fair_ord", order.size() > i ? order[i] : -1, fairExp[i]);
      chk("fair_len", beats.size() > i ? beats[i] : -1, 2);
    end

    // Forced end at MaxBurst on a long burst.
    doReset('0);
    blen[2] = 40;
    blen[4] = 4;
    en = 8'b0001_0100;
    for (int i = 0; i < 50; i++) cycle();
    chk("max_o0", order.size() > 0 ? order[0] : -1, 2);
    chk("max_o1", order.size() > 1 ? order[1] : -1, 4);
    chk("max_o2", order.size() > 2 ? order[2] : -1, 2);
    chk("max_b0", beats.size() > 0 ? beats[0] : -1, MB);
    chk("max_b1", beats.size() > 1 ? beats[1] : -1, 4);

    // Backpressure mid-burst holds the grant.
    doReset('0);
    blen[1] = 8;
    en = 8'b0100_0010;
    for (int i = 0; i < 20 && cnt[1] != 3; i++) cycle();
    chk("bp_pre", cnt[1], 3);
    resReady = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("bp_grant", 64'(grant), 64'h02);
      chk("bp_ready", 64'(reqReady), 64'd0);
    end
    resReady = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    chk("bp_len", beats.size() > 0 ? beats[0] : -1, 8);
    chk("bp_next", order.size() > 1 ? order[1] : -1, 6);

    // Wrap from lastWinner=7 with requests on 1 and 6.
    doReset('0);
    en = 8'b0100_0010;
    for (int i = 0; i < 10; i++) cycle();
    chk("wrap_o0", order.size() > 0 ? order[0] : -1, 1);
    chk("wrap_o1", order.size() > 1 ? order[1] : -1, 6);

`ifdef ARB_TIMEOUT_EN
    // Owner goes silent after three beats; burst is aborted.
    doReset('0);
    blen[3] = 8;
    en = 8'b0000_1000;
    for (int i = 0; i < 20 && cnt[3] != 3; i++) cycle();
    en = 8'b0010_0000;
    toCyc = -1;
    for (int i = 0; i < 100 && grantCyc.size() < 2; i++) cycle();
    chk("to_delay", toCyc - lastHsCyc[3], TO);
    chk("to_next", order.size() > 1 ? order[1] : -1, 5);
    chk("to_gap", grantCyc.size() > 1 ? grantCyc[1] - toCyc : -1, 2);
`endif

    // Random traffic with a reset in the middle.
    doReset('0);
    rnd = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        rstN = 1'b0;
        mReset();
        cycle();
        cycle();
        rstN = 1'b1;
      end
      cycle();
    end
    rnd = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
